// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Decides when the pipeline must stall because forwarding cannot resolve a
//   dependency. Three stall sources are ORed together:
//     - load-use: the instruction in EX is a load whose destination is read in ID
//     - branch compare in ID: the operand is still being produced in EX, or a
//       load is in MEM
//     - HI/LO unit busy: the multicycle MULT/DIV unit is occupied and ID wants it
//   A 4-bit busy counter tracks how long the MULT/DIV unit stays occupied.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   Rs_ID, Rt_ID               source registers of the instruction in ID
//   writereg_EX, writereg_M    destination registers in EX / MEM
//   RegWrite_EX, RegWrite_M    the EX / MEM instruction writes the register file
//   MemtoReg_EX, MemtoReg_M    the EX / MEM instruction is a load
//   Branch_ID                  ID holds a beq/bne that compares in ID
//   MulDiv_ID, MfHiLo_ID       ID holds MULT/DIV, or MFHI/MFLO
//   StallF, StallD, FlushE     hold the PC, hold IF/ID, insert a bubble into ID/EX
//   MulDiv_Busy                the HI/LO unit is occupied
//   MulDiv_Done                one-cycle pulse after an operation completes
//
// Optional build macro HAZARD_STATS_EN adds the statistics outputs
//   stall_cycles (32 bits), muldiv_ops (16 bits).
module hazard_stall_unit #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic [4:0] writereg_EX,
  input  logic [4:0] writereg_M,
  input  logic       RegWrite_EX,
  input  logic       RegWrite_M,
  input  logic       MemtoReg_EX,
  input  logic       MemtoReg_M,
  input  logic       Branch_ID,
  input  logic       MulDiv_ID,
  input  logic       MfHiLo_ID,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       MulDiv_Busy,
  output logic       MulDiv_Done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] muldiv_ops
`endif
);

  localparam logic [3:0] LOAD_CNT = 4'(MULDIV_CYCLES);

  logic [3:0] busy_cnt;
  logic       busy;
  logic       ex_hit;
  logic       m_load_hit;
  logic       lwstall;
  logic       brstall;
  logic       mdstall;
  logic       stall;
  logic       issue;

  // A writer of $0 never matches.
  always_comb begin
    ex_hit     = RegWrite_EX && (writereg_EX != '0) &&
                 ((writereg_EX == Rs_ID) || (writereg_EX == Rt_ID));
    m_load_hit = MemtoReg_M && RegWrite_M && (writereg_M != '0) &&
                 ((writereg_M == Rs_ID) || (writereg_M == Rt_ID));
  end

  always_comb begin
    busy    = (busy_cnt != '0);
    lwstall = MemtoReg_EX && ex_hit;
    // An ALU result in MEM is forwarded to the ID comparator, so only a load
    // in MEM stalls the branch.
    brstall = Branch_ID && (ex_hit || m_load_hit);
    mdstall = busy && (MulDiv_ID || MfHiLo_ID);
    stall   = lwstall || brstall || mdstall;
    issue   = MulDiv_ID && !stall;
  end

  // Outputs are forced low while reset is held, even though the stall terms
  // are combinational from the ID/EX/MEM inputs.
  always_comb begin
    StallF      = stall && rst_n;
    StallD      = stall && rst_n;
    FlushE      = stall && rst_n;
    MulDiv_Busy = busy && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt    <= '0;
      MulDiv_Done <= 1'b0;
    end else begin
      if (issue) begin
        busy_cnt <= LOAD_CNT;
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - 4'd1;
      end
      // Completion is the 1 -> 0 transition; a reload on the same edge
      // cancels it.
      MulDiv_Done <= (busy_cnt == 4'd1) && !issue;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      muldiv_ops   <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (issue) muldiv_ops   <= muldiv_ops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs_ID, Rt_ID, writereg_EX, writereg_M;
  logic       RegWrite_EX, RegWrite_M, MemtoReg_EX, MemtoReg_M;
  logic       Branch_ID, MulDiv_ID, MfHiLo_ID;
  logic       StallF, StallD, FlushE, MulDiv_Busy, MulDiv_Done;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] muldiv_ops;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string      tag;
    logic [4:0] v;   // {StallF, StallD, FlushE, MulDiv_Busy, MulDiv_Done}
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULDIV_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Rs_ID       (Rs_ID),
    .Rt_ID       (Rt_ID),
    .writereg_EX (writereg_EX),
    .writereg_M  (writereg_M),
    .RegWrite_EX (RegWrite_EX),
    .RegWrite_M  (RegWrite_M),
    .MemtoReg_EX (MemtoReg_EX),
    .MemtoReg_M  (MemtoReg_M),
    .Branch_ID   (Branch_ID),
    .MulDiv_ID   (MulDiv_ID),
    .MfHiLo_ID   (MfHiLo_ID),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushE      (FlushE),
    .MulDiv_Busy (MulDiv_Busy),
    .MulDiv_Done (MulDiv_Done)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .muldiv_ops  (muldiv_ops)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic s, input logic b, input logic d);
    exp_t e;
    e.tag = tag;
    e.v   = {s, s, s, b, d};
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, {27'd0, StallF, StallD, FlushE, MulDiv_Busy, MulDiv_Done}, {27'd0, e.v});
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled 4 later.
  task automatic cyc(input string tag, input logic s, input logic b, input logic d);
    push(tag, s, b, d);
    #3;
    pop_compare();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    Rs_ID = '0; Rt_ID = '0; writereg_EX = '0; writereg_M = '0;
    RegWrite_EX = 1'b0; RegWrite_M = 1'b0; MemtoReg_EX = 1'b0; MemtoReg_M = 1'b0;
    Branch_ID = 1'b0; MulDiv_ID = 1'b0; MfHiLo_ID = 1'b0;
  endtask

  task automatic set_load_use();
    writereg_EX = 5'd5; MemtoReg_EX = 1'b1; RegWrite_EX = 1'b1; Rs_ID = 5'd5;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    set_load_use();            // a hazard pattern must be masked during reset
    #2;
    push("reset_outputs", 1'b0, 1'b0, 1'b0);
    pop_compare();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use
    clear_in(); set_load_use();
    cyc("lw_rs", 1'b1, 1'b0, 1'b0);
    clear_in(); set_load_use(); Rs_ID = 5'd1; Rt_ID = 5'd5;
    cyc("lw_rt", 1'b1, 1'b0, 1'b0);
    clear_in(); set_load_use(); writereg_EX = 5'd0; Rs_ID = 5'd0;
    cyc("lw_reg0", 1'b0, 1'b0, 1'b0);
    clear_in(); set_load_use(); RegWrite_EX = 1'b0;
    cyc("lw_nowrite", 1'b0, 1'b0, 1'b0);
    clear_in(); set_load_use(); Rs_ID = 5'd6;
    cyc("lw_nomatch", 1'b0, 1'b0, 1'b0);

    // Branch compare in ID
    clear_in(); Branch_ID = 1'b1; Rt_ID = 5'd9; writereg_EX = 5'd9; RegWrite_EX = 1'b1;
    cyc("br_alu_ex", 1'b1, 1'b0, 1'b0);
    clear_in(); Rt_ID = 5'd9; writereg_EX = 5'd9; RegWrite_EX = 1'b1;
    cyc("alu_ex_nobranch", 1'b0, 1'b0, 1'b0);
    clear_in(); Branch_ID = 1'b1; Rt_ID = 5'd9; writereg_M = 5'd9; RegWrite_M = 1'b1;
    cyc("br_alu_mem", 1'b0, 1'b0, 1'b0);
    MemtoReg_M = 1'b1;
    cyc("br_load_mem", 1'b1, 1'b0, 1'b0);
    writereg_M = 5'd0; Rt_ID = 5'd0;
    cyc("br_load_mem_reg0", 1'b0, 1'b0, 1'b0);
    clear_in(); Branch_ID = 1'b1; Rs_ID = 5'd3; writereg_EX = 5'd3; RegWrite_EX = 1'b1;
    writereg_EX = 5'd0; Rs_ID = 5'd0;
    cyc("br_ex_reg0", 1'b0, 1'b0, 1'b0);

    // MULT then MFHI
    clear_in(); MulDiv_ID = 1'b1;
    cyc("mult_issue", 1'b0, 1'b0, 1'b0);
    clear_in(); MfHiLo_ID = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) cyc($sformatf("mfhi_wait%0d", i), 1'b1, 1'b1, 1'b0);
    cyc("mfhi_go_done", 1'b0, 1'b0, 1'b1);
    cyc("done_pulse_end", 1'b0, 1'b0, 1'b0);

    // Issue blocked by a load-use stall
    clear_in(); set_load_use(); MulDiv_ID = 1'b1;
    cyc("issue_blocked", 1'b1, 1'b0, 1'b0);
    clear_in(); MulDiv_ID = 1'b1;
    cyc("issue_released", 1'b0, 1'b0, 1'b0);
    clear_in();
    for (int unsigned i = 1; i <= 4; i++) cyc($sformatf("busy_after_release%0d", i), 1'b0, 1'b1, 1'b0);
    cyc("release_done", 1'b0, 1'b0, 1'b1);

    // Reset mid-operation
    clear_in(); MulDiv_ID = 1'b1;
    cyc("mid_issue", 1'b0, 1'b0, 1'b0);
    clear_in(); MfHiLo_ID = 1'b1;
    cyc("mid_cnt4", 1'b1, 1'b1, 1'b0);
    cyc("mid_cnt3", 1'b1, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    push("reset_mid_op", 1'b0, 1'b0, 1'b0);
    pop_compare();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("after_reset_mfhi", 1'b0, 1'b0, 1'b0);

`ifdef HAZARD_STATS_EN
    clear_in();
    rst_n = 1'b0;
    #1;
    check("stats_reset_stalls", stall_cycles, 32'd0);
    check("stats_reset_ops", {16'd0, muldiv_ops}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_load_use();
    for (int unsigned i = 0; i < 3; i++) cyc("stats_stall", 1'b1, 1'b0, 1'b0);
    clear_in(); MulDiv_ID = 1'b1;
    cyc("stats_issue", 1'b0, 1'b0, 1'b0);
    clear_in();
    check("stats_stall_cycles", stall_cycles, 32'd3);
    check("stats_muldiv_ops", {16'd0, muldiv_ops}, 32'd1);
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Decides when the pipeline must stall because forwarding cannot resolve a dependency.
- Covers three cases: load-use hazards, early-branch compare hazards in ID, and occupancy of a multicycle MULT/DIV unit.
- Sits beside the forwarding logic. It drives StallF, StallD and FlushE into the fetch/decode pipeline registers and the ID/EX register.
- Holds a busy counter for the multicycle HI/LO unit.

Parameters:
- MULDIV_CYCLES, 4, number of cycles a MULT/DIV occupies the HI/LO unit after issue (legal range 1..15).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- Rs_ID  input  5  rs of the instruction in ID.
- Rt_ID  input  5  rt of the instruction in ID.
- writereg_EX  input  5  destination register of the instruction in EX.
- writereg_M  input  5  destination register of the instruction in MEM.
- RegWrite_EX  input  1  EX instruction writes the register file.
- RegWrite_M  input  1  MEM instruction writes the register file.
- MemtoReg_EX  input  1  EX instruction is a load.
- MemtoReg_M  input  1  MEM instruction is a load.
- Branch_ID  input  1  ID instruction is a beq/bne compared in ID.
- MulDiv_ID  input  1  ID instruction is MULT/MULTU/DIV/DIVU.
- MfHiLo_ID  input  1  ID instruction is MFHI/MFLO.
- StallF  output  1  hold the PC.
- StallD  output  1  hold the IF/ID register.
- FlushE  output  1  insert a bubble into ID/EX.
- MulDiv_Busy  output  1  HI/LO unit occupied.
- MulDiv_Done  output  1  one-cycle pulse when an operation completes.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous and active-low.
- Reset state: while rst_n=0, busy_cnt=0 and MulDiv_Done=0. StallF, StallD, FlushE and MulDiv_Busy are forced to 0.
- Register 0 rule: a register match requires the writer's register to be non-zero. $0 never causes a stall.
- lwstall = MemtoReg_EX & RegWrite_EX & (writereg_EX!=0) & (writereg_EX==Rs_ID | writereg_EX==Rt_ID).
- brstall = Branch_ID & ( (RegWrite_EX & writereg_EX!=0 & writereg_EX in {Rs_ID,Rt_ID}) | (MemtoReg_M & RegWrite_M & writereg_M!=0 & writereg_M in {Rs_ID,Rt_ID}) ).
  - An ALU result already in MEM is forwarded to ID and does not stall.
- mdstall = MulDiv_Busy & (MulDiv_ID | MfHiLo_ID).
- stall = lwstall | brstall | mdstall. StallF = StallD = FlushE = stall.
  - Combinational, same-cycle response.
- busy_cnt:
  - Width 4 bits, unsigned.
  - Priority 1: if MulDiv_ID & !stall, load MULDIV_CYCLES.
  - Priority 2: else if busy_cnt!=0, decrement.
  - Otherwise hold.
  - Never decrements below 0.
- MulDiv_Busy = (busy_cnt!=0). Combinational from the register.
- MulDiv_Done:
  - Registered. It is 1 in the cycle after busy_cnt goes from 1 to 0.
  - It is not asserted if a new issue reloads the counter in that same cycle. Back-to-back issue is impossible anyway, since mdstall blocks issue while busy.
- Issue timing:
  - A MULT/DIV is issued on the edge where MulDiv_ID=1 and stall=0.
  - Busy is visible from the next cycle. A dependent MFHI directly behind the MULT stalls exactly MULDIV_CYCLES cycles.
- Simultaneous events:
  - MulDiv_ID with lwstall=1 (operand from a load): no issue; the counter continues decrementing or idle.
  - The stall sources are ORed. There is no priority between them.
- Reset mid-operation: busy_cnt clears immediately. Busy and Done drop with no edge required.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, add two extra outputs:
  - stall_cycles, 32 bits: increments on every rising edge where stall=1. It wraps from 0xFFFFFFFF to 0.
  - muldiv_ops, 16 bits: increments on every issue. It wraps.
- Both counters clear on rst_n=0.
- When the macro is undefined, these ports and registers do not exist, and the remaining behaviour is identical.

Test Plan:
- Load-use: writereg_EX=5, MemtoReg_EX=1, RegWrite_EX=1, Rs_ID=5 -> StallF=StallD=FlushE=1 that cycle. Same case with writereg_EX=0 -> all 0.
- Branch vs ALU in EX: Branch_ID=1, Rt_ID=9, writereg_EX=9, RegWrite_EX=1, MemtoReg_EX=0 -> stall=1. Same register in MEM, with MemtoReg_M=0 -> stall=0; with MemtoReg_M=1 -> stall=1.
- MULT then MFHI, MULDIV_CYCLES=4: MulDiv_ID=1 at cycle 0, MfHiLo_ID=1 from cycle 1 -> stall=1 in cycles 1-4, stall=0 in cycle 5. MulDiv_Done=1 in cycle 5 only.
- Issue blocked: MulDiv_ID=1 with lwstall=1 -> busy_cnt stays 0. Release the stall next cycle -> busy_cnt=4 after that edge.
- Reset mid-op: assert rst_n=0 while busy_cnt=2 -> MulDiv_Busy=0 immediately with no clock edge. After release, MfHiLo_ID=1 -> no stall.
- With HAZARD_STATS_EN: 3 stalled cycles plus 1 issue -> stall_cycles=3, muldiv_ops=1. Preload near the maximum and check the wrap to 0.
